// File: rtl/tdm_burst_acc.sv
// =============================================================================
// tdm_burst_acc : per-channel TDM burst accumulator with 2-entry output FIFO.
// Optional: define TDM_ACC_SAT_EN to clamp pushed sums to the PW-bit range.
// Revision: 1.0
// =============================================================================
`default_nettype none

module tdm_burst_acc #(
    parameter  int WIDTH     = 8,
    parameter  int CHANNELS  = 4,
    parameter  int BURST_LEN = 8,
    localparam int PW        = 2 * WIDTH,
    localparam int CW        = $clog2(CHANNELS),
    localparam int AW        = PW + $clog2(BURST_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] din_p_i,
    input  logic          din_valid_i,
    input  logic [CW-1:0] din_ch_i,
    input  logic          clear_i,
    output logic [AW-1:0] dout_sum_o,
    output logic [CW-1:0] dout_ch_o,
    output logic          dout_valid_o,
    input  logic          dout_ready_i,
    output logic          ovf_o
);

    localparam int             NW       = $clog2(BURST_LEN);
    localparam logic [NW-1:0]  CNT_LAST = NW'(BURST_LEN - 1);
    localparam logic [CW:0]    CH_LIM   = (CW + 1)'(CHANNELS);
`ifdef TDM_ACC_SAT_EN
    localparam logic [AW-1:0]  SAT_MAX  = {{(AW-PW+1){1'b0}}, {(PW-1){1'b1}}};
    localparam logic [AW-1:0]  SAT_MIN  = {{(AW-PW+1){1'b1}}, {(PW-1){1'b0}}};
`endif

    logic [AW-1:0] acc_q [CHANNELS];
    logic [NW-1:0] cnt_q [CHANNELS];

    logic [AW-1:0] head_sum_q, tail_sum_q;
    logic [CW-1:0] head_ch_q, tail_ch_q;
    logic [1:0]    count_q;
    logic          ovf_q;

    logic [AW-1:0] sum_d;
    logic [AW-1:0] push_val_d;
    logic          accept_d, last_d, push_d, pop_d, full_d, push_ok_d;

    always_comb begin
        accept_d   = din_valid_i && ({1'b0, din_ch_i} < CH_LIM) && !clear_i;
        sum_d      = acc_q[din_ch_i] + {{(AW-PW){din_p_i[PW-1]}}, din_p_i};
        last_d     = (cnt_q[din_ch_i] == CNT_LAST);
        push_d     = accept_d && last_d;
        pop_d      = (count_q != 2'd0) && dout_ready_i;
        full_d     = (count_q == 2'd2);
        // A pop frees the slot a full FIFO needs, so push and pop both succeed.
        push_ok_d  = push_d && (!full_d || pop_d);
`ifdef TDM_ACC_SAT_EN
        if (sum_d[AW-1:PW-1] != {(AW-PW+1){sum_d[AW-1]}})
            push_val_d = sum_d[AW-1] ? SAT_MIN : SAT_MAX;
        else
            push_val_d = sum_d;
`else
        push_val_d = sum_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else if (accept_d) begin
            if (last_d) begin
                acc_q[din_ch_i] <= '0;
                cnt_q[din_ch_i] <= '0;
            end else begin
                acc_q[din_ch_i] <= sum_d;
                cnt_q[din_ch_i] <= cnt_q[din_ch_i] + NW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_sum_q <= '0;
            head_ch_q  <= '0;
            tail_sum_q <= '0;
            tail_ch_q  <= '0;
            count_q    <= 2'd0;
            ovf_q      <= 1'b0;
        end else begin
            if (push_d && full_d && !pop_d)
                ovf_q <= 1'b1;
            case ({push_ok_d, pop_d})
                2'b01: begin
                    head_sum_q <= tail_sum_q;
                    head_ch_q  <= tail_ch_q;
                    count_q    <= count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_sum_q <= push_val_d;
                        head_ch_q  <= din_ch_i;
                    end else begin
                        tail_sum_q <= push_val_d;
                        tail_ch_q  <= din_ch_i;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_sum_q <= push_val_d;
                        head_ch_q  <= din_ch_i;
                    end else begin
                        head_sum_q <= tail_sum_q;
                        head_ch_q  <= tail_ch_q;
                        tail_sum_q <= push_val_d;
                        tail_ch_q  <= din_ch_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout_sum_o   = head_sum_q;
    assign dout_ch_o    = head_ch_q;
    assign dout_valid_o = (count_q != 2'd0);
    assign ovf_o        = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_tdm_burst_acc.sv
// =============================================================================
// tb_tdm_burst_acc : directed and randomized checks of tdm_burst_acc
// (WIDTH=8, CHANNELS=4, BURST_LEN=4) against a queue-based reference model.
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_tdm_burst_acc;

    logic        clk;
    logic        rst;
    logic [15:0] din_p_i;
    logic        din_valid_i;
    logic [1:0]  din_ch_i;
    logic        clear_i;
    logic [17:0] dout_sum_o;
    logic [1:0]  dout_ch_o;
    logic        dout_valid_o;
    logic        dout_ready_i;
    logic        ovf_o;

    int total = 0;
    int bad   = 0;

    // Reference model: plain integers per channel and a queue for the FIFO.
    int m_acc [4];
    int m_cnt [4];
    int qs[$];
    int qc[$];
    bit m_ovf;

    tdm_burst_acc #(.WIDTH(8), .CHANNELS(4), .BURST_LEN(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .din_p_i      (din_p_i),
        .din_valid_i  (din_valid_i),
        .din_ch_i     (din_ch_i),
        .clear_i      (clear_i),
        .dout_sum_o   (dout_sum_o),
        .dout_ch_o    (dout_ch_o),
        .dout_valid_o (dout_valid_o),
        .dout_ready_i (dout_ready_i),
        .ovf_o        (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat16(input int s);
`ifdef TDM_ACC_SAT_EN
        if (s > 32767)  return 32767;
        if (s < -32768) return -32768;
`endif
        return s;
    endfunction

    function automatic void model_step(input bit v, input int ch, input int p,
                                       input bit clr, input bit rdy, input bit rs);
        int n;
        bit pop;
        int s;
        if (rs) begin
            for (int i = 0; i < 4; i++) begin m_acc[i] = 0; m_cnt[i] = 0; end
            qs.delete(); qc.delete(); m_ovf = 0;
            return;
        end
        n   = qs.size();
        pop = (n > 0) && rdy;
        if (pop) begin qs.delete(0); qc.delete(0); end
        if (clr) begin
            for (int i = 0; i < 4; i++) begin m_acc[i] = 0; m_cnt[i] = 0; end
        end else if (v && ch < 4) begin
            s = m_acc[ch] + p;
            if (m_cnt[ch] == 3) begin
                if (n < 2 || pop) begin qs.push_back(sat16(s)); qc.push_back(ch); end
                else m_ovf = 1;
                m_acc[ch] = 0;
                m_cnt[ch] = 0;
            end else begin
                m_acc[ch] = s;
                m_cnt[ch] = m_cnt[ch] + 1;
            end
        end
    endfunction

    task automatic tick(input bit v, input int ch, input int p,
                        input bit clr, input bit rdy, input bit rs);
        din_valid_i  = v;
        din_ch_i     = ch[1:0];
        din_p_i      = p[15:0];
        clear_i      = clr;
        dout_ready_i = rdy;
        rst          = rs;
        @(posedge clk);
        model_step(v, ch, p, clr, rdy, rs);
        #1;
    endtask

    task automatic test_reset();
        tick(0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 1);
        total++; if (dout_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", dout_valid_o); end
        total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf_o); end
        total++; if (dout_sum_o !== 18'd0) begin bad++; $display("FAIL reset_sum got=%0d exp=0", dout_sum_o); end
        total++; if (dout_ch_o !== 2'd0) begin bad++; $display("FAIL reset_ch got=%0d exp=0", dout_ch_o); end
    endtask

    task automatic test_basic();
        int vals[4] = '{100, -50, 7, 1};
        for (int i = 0; i < 4; i++) begin
            tick(1, 0, vals[i], 0, 1, 0);
            if (i < 3) begin
                total++; if (dout_valid_o !== 1'b0) begin bad++; $display("FAIL basic_early_valid i=%0d got=%b exp=0", i, dout_valid_o); end
            end
        end
        total++; if (dout_valid_o !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", dout_valid_o); end
        total++; if ($signed(dout_sum_o) !== 58) begin bad++; $display("FAIL basic_sum got=%0d exp=58", $signed(dout_sum_o)); end
        total++; if (dout_ch_o !== 2'd0) begin bad++; $display("FAIL basic_ch got=%0d exp=0", dout_ch_o); end
        tick(0, 0, 0, 0, 1, 0);
        total++; if (dout_valid_o !== 1'b0) begin bad++; $display("FAIL basic_one_cycle got=%b exp=0", dout_valid_o); end
    endtask

    task automatic test_interleave();
        for (int i = 0; i < 4; i++) begin
            tick(1, 1, i + 1, 0, 1, 0);
            tick(1, 2, -1, 0, 1, 0);
            if (i == 3) begin
                total++; if (dout_valid_o !== 1'b1 || $signed(dout_sum_o) !== -4 || dout_ch_o !== 2'd2) begin
                    bad++; $display("FAIL inter_ch2 got v=%b sum=%0d ch=%0d exp v=1 sum=-4 ch=2", dout_valid_o, $signed(dout_sum_o), dout_ch_o);
                end
            end
        end
        // Re-run the last pair, checking ch1 appears between the two fourth samples.
        for (int i = 0; i < 3; i++) begin
            tick(1, 1, i + 1, 0, 1, 0);
            tick(1, 2, -1, 0, 1, 0);
        end
        tick(1, 1, 4, 0, 1, 0);
        total++; if (dout_valid_o !== 1'b1 || $signed(dout_sum_o) !== 10 || dout_ch_o !== 2'd1) begin
            bad++; $display("FAIL inter_ch1 got v=%b sum=%0d ch=%0d exp v=1 sum=10 ch=1", dout_valid_o, $signed(dout_sum_o), dout_ch_o);
        end
        tick(1, 2, -1, 0, 1, 0);
        total++; if ($signed(dout_sum_o) !== -4 || dout_ch_o !== 2'd2) begin
            bad++; $display("FAIL inter_ch2_next got sum=%0d ch=%0d exp sum=-4 ch=2", $signed(dout_sum_o), dout_ch_o);
        end
        tick(0, 0, 0, 0, 1, 0);
        total++; if (dout_valid_o !== 1'b0) begin bad++; $display("FAIL inter_drain got=%b exp=0", dout_valid_o); end
    endtask

    task automatic test_saturation();
        int exp_hi, exp_lo;
`ifdef TDM_ACC_SAT_EN
        exp_hi = 32767;  exp_lo = -32768;
`else
        exp_hi = 65536;  exp_lo = -131072;
`endif
        for (int i = 0; i < 4; i++) tick(1, 3, 16384, 0, 1, 0);
        total++; if (dout_valid_o !== 1'b1 || $signed(dout_sum_o) !== exp_hi || dout_ch_o !== 2'd3) begin
            bad++; $display("FAIL sat_high got v=%b sum=%0d ch=%0d exp sum=%0d ch=3", dout_valid_o, $signed(dout_sum_o), dout_ch_o, exp_hi);
        end
        for (int i = 0; i < 4; i++) tick(1, 3, -32768, 0, 1, 0);
        total++; if (dout_valid_o !== 1'b1 || $signed(dout_sum_o) !== exp_lo) begin
            bad++; $display("FAIL sat_low got v=%b sum=%0d exp sum=%0d", dout_valid_o, $signed(dout_sum_o), exp_lo);
        end
        tick(0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 4; i++) tick(1, c, c + 1, 0, 0, 0);
            total++; if (dout_valid_o !== 1'b1 || $signed(dout_sum_o) !== 4 || dout_ch_o !== 2'd0) begin
                bad++; $display("FAIL bp_hold c=%0d got v=%b sum=%0d ch=%0d exp v=1 sum=4 ch=0", c, dout_valid_o, $signed(dout_sum_o), dout_ch_o);
            end
            total++; if (ovf_o !== (c == 2)) begin bad++; $display("FAIL bp_ovf c=%0d got=%b exp=%b", c, ovf_o, (c == 2)); end
        end
        tick(0, 0, 0, 0, 1, 0);
        total++; if (dout_valid_o !== 1'b1 || $signed(dout_sum_o) !== 8 || dout_ch_o !== 2'd1) begin
            bad++; $display("FAIL bp_second got v=%b sum=%0d ch=%0d exp v=1 sum=8 ch=1", dout_valid_o, $signed(dout_sum_o), dout_ch_o);
        end
        tick(0, 0, 0, 0, 1, 0);
        total++; if (dout_valid_o !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", dout_valid_o); end
        total++; if (ovf_o !== 1'b1) begin bad++; $display("FAIL bp_ovf_sticky got=%b exp=1", ovf_o); end
    endtask

    task automatic test_rst_mid_burst();
        int outs = 0;
        tick(1, 0, 5, 0, 1, 0);
        tick(1, 0, 5, 0, 1, 0);
        tick(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 6; i++) begin
            tick(i < 4, 0, 1, 0, 1, 0);
            if (dout_valid_o === 1'b1) begin
                outs++;
                total++; if ($signed(dout_sum_o) !== 4) begin bad++; $display("FAIL rst_sum got=%0d exp=4", $signed(dout_sum_o)); end
            end
        end
        total++; if (outs != 1) begin bad++; $display("FAIL rst_count got=%0d exp=1", outs); end
        total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", ovf_o); end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 4; i++) tick(1, 3, 3, 0, 0, 0);
        tick(1, 1, 9, 0, 0, 0);
        tick(1, 1, 9, 0, 0, 0);
        tick(1, 1, 9, 1, 0, 0);
        for (int i = 0; i < 4; i++) tick(1, 1, 2, 0, 0, 0);
        total++; if (dout_valid_o !== 1'b1 || $signed(dout_sum_o) !== 12 || dout_ch_o !== 2'd3) begin
            bad++; $display("FAIL clr_keep got v=%b sum=%0d ch=%0d exp v=1 sum=12 ch=3", dout_valid_o, $signed(dout_sum_o), dout_ch_o);
        end
        tick(0, 0, 0, 0, 1, 0);
        total++; if (dout_valid_o !== 1'b1 || $signed(dout_sum_o) !== 8 || dout_ch_o !== 2'd1) begin
            bad++; $display("FAIL clr_sum got v=%b sum=%0d ch=%0d exp v=1 sum=8 ch=1", dout_valid_o, $signed(dout_sum_o), dout_ch_o);
        end
        tick(0, 0, 0, 0, 1, 0);
        total++; if (dout_valid_o !== 1'b0 || ovf_o !== 1'b0) begin
            bad++; $display("FAIL clr_end got v=%b ovf=%b exp v=0 ovf=0", dout_valid_o, ovf_o);
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 3),
                 int'($urandom_range(0, 65535)) - 32768,
                 $urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, 0);
            total++; if (dout_valid_o !== (qs.size() > 0)) begin
                bad++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, dout_valid_o, (qs.size() > 0));
            end
            total++; if (ovf_o !== m_ovf) begin bad++; $display("FAIL rand_ovf cyc=%0d got=%b exp=%b", cyc, ovf_o, m_ovf); end
            if (qs.size() > 0) begin
                total++; if ($signed(dout_sum_o) !== qs[0] || dout_ch_o !== qc[0][1:0]) begin
                    bad++; $display("FAIL rand_head cyc=%0d got sum=%0d ch=%0d exp sum=%0d ch=%0d", cyc, $signed(dout_sum_o), dout_ch_o, qs[0], qc[0]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; din_p_i = '0; din_valid_i = 1'b0; din_ch_i = '0;
        clear_i = 1'b0; dout_ready_i = 1'b0;
        test_reset();
        test_basic();
        test_interleave();
        test_saturation();
        test_backpressure();
        test_rst_mid_burst();
        test_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tdm_burst_acc.md
# tdm_burst_acc

Per-channel burst accumulator sitting directly downstream of the signed operand multiplier in the TDM datapath. It consumes time-multiplexed 2·WIDTH-bit signed products, each tagged with a channel, and keeps an independent running sum per channel. After BURST_LEN products of a channel it emits that channel's sum through a 2-entry output FIFO with a valid/ready handshake. The input has no stall path, so the block absorbs output backpressure by dropping results and flagging overflow.

## Interface
- WIDTH, 8, multiplier operand width; product width PW = 2·WIDTH
- CHANNELS, 4, number of TDM channels (≥2); CW = $clog2(CHANNELS)
- BURST_LEN, 8, products per channel per burst (≥2); AW = PW + $clog2(BURST_LEN)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- din_p  in  PW  signed product from multiplier
- din_valid  in  1  din_p/din_ch valid this cycle
- din_ch  in  CW  channel tag of din_p; values ≥ CHANNELS ignored
- clear  in  1  synchronous: zero all sums and burst counters; FIFO untouched
- dout_sum  out  AW  signed burst sum (FIFO head)
- dout_ch  out  CW  channel of dout_sum
- dout_valid  out  1  FIFO non-empty
- dout_ready  in  1  consumer accepts head when dout_valid & dout_ready
- ovf  out  1  sticky: a completed burst was dropped (FIFO full)

## Operation
- Per channel c: acc[c] (AW bits, signed), cnt[c] (0..BURST_LEN-1).
- Accepted sample: din_valid=1 and din_ch<CHANNELS. Then sum = acc[c] + sign-extended din_p.
  - If cnt[c] < BURST_LEN-1: acc[c] ← sum, cnt[c] ← cnt[c]+1.
  - If cnt[c] = BURST_LEN-1 (last): push {sum, c} to FIFO, acc[c] ← 0, cnt[c] ← 0.
- AW guard bits guarantee no internal wrap for any BURST_LEN products.
- FIFO: depth 2, in-order. Pop on dout_valid & dout_ready.
- Push when FIFO full and no pop that cycle: result discarded, ovf ← 1. The channel still resets acc/cnt.
- Push and pop in the same cycle with FIFO full: both succeed, no overflow.
- clear=1: all acc/cnt ← 0; any sample presented the same cycle is discarded. FIFO contents and ovf are retained.
- ovf is cleared only by rst.
- Out-of-range din_ch: sample dropped silently. No state change.

## Timing
- Reset values: dout_valid=0, ovf=0, dout_sum=0, dout_ch=0; all acc/cnt=0; FIFO empty.
- rst mid-burst: partial sums lost; FIFO flushed; the next accepted sample starts a fresh burst.
- Latency: the last sample accepted at edge t gives dout_valid=1 after edge t (visible in cycle t+1) when the FIFO was empty. Sum is registered; no combinational path din→dout.
- dout_sum and dout_ch hold stable while dout_valid=1 and dout_ready=0.
- Throughput: one sample per cycle, any interleaving of channels, including back-to-back same channel.
- dout_ready may toggle freely; dout_valid does not depend combinationally on dout_ready.

## Configuration
- TDM_ACC_SAT_EN:
  - Defined: before the FIFO push, the sum is clamped to the PW-bit signed range [-2^(PW-1), 2^(PW-1)-1] and sign-extended to AW.
  - Undefined: the full AW-bit sum is pushed unmodified.
- Internal acc width is AW in both cases.

## Test plan
All scenarios use WIDTH=8, CHANNELS=4, BURST_LEN=4 (PW=16, AW=18).
- ch0 products 100, -50, 7, 1, consecutive, dout_ready=1 → one cycle after the 4th: dout_valid=1, dout_sum=58, dout_ch=0, for one cycle.
- Interleave ch1: 1, 2, 3, 4 with ch2: -1, -1, -1, -1 (alternating) → ch1 sum 10 emitted first, then ch2 sum -4 the next cycle.
- ch3 four × 16384 → dout_sum=65536 without macro; 32767 with TDM_ACC_SAT_EN. Four × -32768 → -131072 / -32768.
- dout_ready=0; complete bursts on ch0 (sum 4), ch1 (sum 8), ch2 (sum 12) → first two held in order, third dropped, ovf=1. Raise dout_ready → 4 then 8 popped, then dout_valid=0; ovf stays 1.
- ch0 samples 5, 5, then rst for 1 cycle, then four × 1 → single output, sum 4, ovf=0.
- ch1 samples 9, 9, then clear with a concurrent ch1 sample 9, then four × 2 → single output, sum 8; earlier FIFO entries unaffected.
